// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart_tx byte port
// among NUM_REQ packet sources. A granted requester holds the transmitter
// until it sends a byte flagged last, so packets never interleave.
// Optional feature macro: UART_ARB_TIMEOUT_EN (forced release of a lock
// whose owner goes idle for TIMEOUT cycles).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clkin,
  input  logic                       resetn_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_timeout
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic           grant_active_q, grant_active_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           arb_timeout_q, arb_timeout_d;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]    idle_cnt_q, idle_cnt_d;
`else
  logic           unused_timeout;
  assign unused_timeout = ^(16'(TIMEOUT));
`endif

  logic [IDW-1:0] rr_sel;
  logic [IDW-1:0] rr_cand;
  logic           rr_found;
  logic           sel_valid;
  logic           sel_last;
  logic [7:0]     sel_byte;
  logic           accept;

  // Round-robin pick: first valid requester searching upward from last_grant+1
  always_comb begin
    rr_sel   = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_cand = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!rr_found && req_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  // Select the locked requester's signals and drive its ready from the output register state
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_byte  = 8'h00;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_byte  = req_data[8*i +: 8];
        req_ready[i] = (state_q == LOCK) && (!tx_valid_q || tx_ready);
      end
    end
    accept = (state_q == LOCK) && sel_valid && (!tx_valid_q || tx_ready);
  end

  // Next-state logic for arbitration FSM, output register and optional idle counter
  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    grant_active_d = grant_active_q;
    tx_valid_d     = tx_valid_q;
    tx_data_d      = tx_data_q;
    arb_timeout_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    idle_cnt_d     = idle_cnt_q;
`endif

    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = sel_byte;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d        = LOCK;
          grant_id_d     = rr_sel;
          grant_active_d = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
          idle_cnt_d     = '0;
`endif
        end
      end
      LOCK: begin
        if (accept) begin
`ifdef UART_ARB_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
          if (sel_last) begin
            state_d        = IDLE;
            last_grant_d   = grant_id_q;
            grant_active_d = 1'b0;
          end
`ifdef UART_ARB_TIMEOUT_EN
        end else if (!sel_valid) begin
          // The increment that makes the count equal TIMEOUT releases the lock.
          if (idle_cnt_q == 16'(TIMEOUT - 1)) begin
            state_d        = IDLE;
            last_grant_d   = grant_id_q;
            grant_active_d = 1'b0;
            arb_timeout_d  = 1'b1;
            idle_cnt_d     = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
`endif
        end
      end
      default: begin
        state_d        = IDLE;
        grant_active_d = 1'b0;
      end
    endcase
  end

  // Register all state; reset discards any pending output byte
  always_ff @(posedge clkin) begin
    if (!resetn_in) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= IDW'(NUM_REQ - 1);
      grant_active_q <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      arb_timeout_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      grant_active_q <= grant_active_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      arb_timeout_q  <= arb_timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_q     <= idle_cnt_d;
`endif
    end
  end

  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign arb_timeout  = arb_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-requester packet queues drive the DUT,
// a scoreboard queue holds the expected serial byte order.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic        clkin = 1'b0;
  logic        resetnIn;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqLast;
  logic [3:0]  reqReady;
  logic        txValid;
  logic [7:0]  txData;
  logic        txReady;
  logic        grantActive;
  logic [1:0]  grantId;
  logic        arbTimeout;

  int checks = 0;
  int errors = 0;

  logic [8:0] reqQ [NUM_REQ][$];
  logic [7:0] expQ [$];
  logic [3:0] holdReq = 4'b0000;

  always #5 clkin = ~clkin;

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (5)
  ) dut (
    .clkin        (clkin),
    .resetn_in    (resetnIn),
    .req_valid    (reqValid),
    .req_data     (reqData),
    .req_last     (reqLast),
    .req_ready    (reqReady),
    .tx_valid     (txValid),
    .tx_data      (txData),
    .tx_ready     (txReady),
    .grant_active (grantActive),
    .grant_id     (grantId),
    .arb_timeout  (arbTimeout)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Queue one byte on a requester
  task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
    reqQ[req].push_back({last, data});
  endtask

  task automatic expectByte(input logic [7:0] data);
    expQ.push_back(data);
  endtask

  // Present the head of each requester queue unless that requester is held off
  task automatic refreshDrive();
    logic [8:0] ent;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqQ[i].size() > 0 && !holdReq[i]) begin
        ent = reqQ[i][0];
        reqValid[i]        = 1'b1;
        reqData[8*i +: 8]  = ent[7:0];
        reqLast[i]         = ent[8];
      end else begin
        reqValid[i]        = 1'b0;
        reqData[8*i +: 8]  = 8'h00;
        reqLast[i]         = 1'b0;
      end
    end
  endtask

  // One clock: sample handshakes at negedge, update drive 1 time unit after posedge
  task automatic tick();
    logic [3:0] acc;
    logic [7:0] e;
    @(negedge clkin);
    acc = reqValid & reqReady & {4{resetnIn}};
    if (resetnIn && txValid && txReady) begin
      if (expQ.size() == 0) begin
        checkOutput("txUnexpected", {24'h0, txData}, 32'h100);
      end else begin
        e = expQ.pop_front();
        checkOutput("txByte", {24'h0, txData}, {24'h0, e});
      end
    end
    @(posedge clkin);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) void'(reqQ[i].pop_front());
    end
    refreshDrive();
  endtask

  task automatic clearQueues();
    for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
    expQ.delete();
    holdReq = 4'b0000;
  endtask

  task automatic doReset();
    resetnIn = 1'b0;
    txReady  = 1'b1;
    clearQueues();
    refreshDrive();
    tick();
    tick();
    resetnIn = 1'b1;
  endtask

  // Run until the scoreboard and output register are empty, bounded
  task automatic drainAll(input string tag);
    int guard = 0;
    int left;
    while ((expQ.size() > 0 || txValid) && guard < 200) begin
      tick();
      guard++;
    end
    left = expQ.size();
    for (int i = 0; i < NUM_REQ; i++) left += reqQ[i].size();
    checkOutput({tag, "Drain"}, 32'(left), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetnIn = 1'b0;
    txReady  = 1'b1;
    reqValid = '0;
    reqData  = '0;
    reqLast  = '0;

    // Reset values
    doReset();
    resetnIn = 1'b0;
    tick();
    checkOutput("rstTxValid",     32'(txValid),     32'd0);
    checkOutput("rstTxData",      32'(txData),      32'd0);
    checkOutput("rstReqReady",    32'(reqReady),    32'd0);
    checkOutput("rstGrantActive", 32'(grantActive), 32'd0);
    checkOutput("rstGrantId",     32'(grantId),     32'd0);
    checkOutput("rstArbTimeout",  32'(arbTimeout),  32'd0);

    // Single two-byte packet from requester 2
    doReset();
    applyStimulus(2, 8'hA5, 1'b0);
    applyStimulus(2, 8'h5A, 1'b1);
    expectByte(8'hA5);
    expectByte(8'h5A);
    refreshDrive();
    tick();
    checkOutput("singleGrantActive", 32'(grantActive), 32'd1);
    checkOutput("singleGrantId",     32'(grantId),     32'd2);
    checkOutput("singleReady",       32'(reqReady),    32'b0100);
    tick();
    checkOutput("singleTxValid",  32'(txValid), 32'd1);
    checkOutput("singleTxDataA5", 32'(txData),  32'hA5);
    tick();
    checkOutput("singleTxData5A", 32'(txData),      32'h5A);
    checkOutput("singleRelease",  32'(grantActive), 32'd0);
    drainAll("single");

    // Round robin with single-byte packets on all requesters
    doReset();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 8'(8'h10 + i), 1'b1);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 8'(8'h20 + i), 1'b1);
    for (int i = 0; i < NUM_REQ; i++) expectByte(8'(8'h10 + i));
    for (int i = 0; i < NUM_REQ; i++) expectByte(8'(8'h20 + i));
    refreshDrive();
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("rrGrantActive", 32'(grantActive), 32'd1);
      checkOutput("rrGrantId",     32'(grantId),     32'(k % 4));
      tick();
      checkOutput("rrBubble",      32'(grantActive), 32'd0);
    end
    drainAll("rr");

    // Requester 0's three-byte packet completes before requester 1
    doReset();
    applyStimulus(0, 8'hC0, 1'b0);
    applyStimulus(0, 8'hC1, 1'b0);
    applyStimulus(0, 8'hC2, 1'b1);
    applyStimulus(1, 8'hD0, 1'b1);
    expectByte(8'hC0);
    expectByte(8'hC1);
    expectByte(8'hC2);
    expectByte(8'hD0);
    refreshDrive();
    tick();
    checkOutput("noIlvGrantId", 32'(grantId),  32'd0);
    checkOutput("noIlvReady",   32'(reqReady), 32'b0001);
    drainAll("noIlv");

    // Backpressure for 10 cycles with a full output register
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3, 8'(8'h30 + i), (i == 3));
      expectByte(8'(8'h30 + i));
    end
    refreshDrive();
    tick();
    checkOutput("bpGrantId", 32'(grantId), 32'd3);
    tick();
    txReady = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("bpTxValid",  32'(txValid),  32'd1);
      checkOutput("bpTxData",   32'(txData),   32'h30);
      checkOutput("bpReqReady", 32'(reqReady), 32'd0);
    end
    txReady = 1'b1;
    tick();
    checkOutput("bpResume", 32'(txData), 32'h31);
    drainAll("bp");

    // Reset after two of four bytes
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'h40 + i), (i == 3));
    expectByte(8'h40);
    refreshDrive();
    tick();
    checkOutput("midGrantId", 32'(grantId), 32'd1);
    tick();
    tick();
    checkOutput("midTxData", 32'(txData), 32'h41);
    resetnIn = 1'b0;
    tick();
    checkOutput("midRstTxValid",     32'(txValid),     32'd0);
    checkOutput("midRstReqReady",    32'(reqReady),    32'd0);
    checkOutput("midRstGrantActive", 32'(grantActive), 32'd0);
    checkOutput("midRstExpLeft",     32'(expQ.size()), 32'd0);
    clearQueues();
    resetnIn = 1'b1;
    applyStimulus(2, 8'h51, 1'b1);
    applyStimulus(0, 8'h50, 1'b1);
    expectByte(8'h50);
    expectByte(8'h51);
    refreshDrive();
    tick();
    checkOutput("midFirstActive", 32'(grantActive), 32'd1);
    checkOutput("midFirstWinner", 32'(grantId),     32'd0);
    drainAll("mid");

`ifdef UART_ARB_TIMEOUT_EN
    // Locked requester 1 goes idle; lock is forced off after 5 cycles
    doReset();
    applyStimulus(1, 8'h70, 1'b0);
    applyStimulus(1, 8'h71, 1'b0);
    applyStimulus(1, 8'h72, 1'b1);
    applyStimulus(2, 8'h80, 1'b1);
    expectByte(8'h70);
    expectByte(8'h80);
    expectByte(8'h71);
    expectByte(8'h72);
    refreshDrive();
    tick();
    checkOutput("toGrantId", 32'(grantId), 32'd1);
    tick();
    holdReq[1] = 1'b1;
    refreshDrive();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("toNoPulse", 32'(arbTimeout), 32'd0);
    end
    tick();
    checkOutput("toPulse",    32'(arbTimeout),  32'd1);
    checkOutput("toReleased", 32'(grantActive), 32'd0);
    tick();
    checkOutput("toPulseEnd",    32'(arbTimeout),  32'd0);
    checkOutput("toNextActive",  32'(grantActive), 32'd1);
    checkOutput("toNextGrantId", 32'(grantId),     32'd2);
    holdReq[1] = 1'b0;
    refreshDrive();
    drainAll("to");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter byte port among NUM_REQ requesters. Each requester sends packets as byte streams with a last flag. Once granted, a requester keeps the transmitter until its packet ends, so packets never interleave on the serial line. The block sits between the on-chip message sources and the uart_tx byte-input interface, in the same clkin/resetn_in domain.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2–8.
- TIMEOUT, 255: idle cycles allowed inside a locked packet before forced release. Only used with UART_ARB_TIMEOUT_EN; legal range 1–65535.

Ports:
- clkin  in  1  the single clock; all logic is on the rising edge.
- resetn_in  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of requester i's packet; qualified by req_valid[i].
- req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when req_valid[i] && req_ready[i].
- tx_valid  out  1  byte valid to uart_tx.
- tx_data  out  8  byte to uart_tx.
- tx_ready  in  1  uart_tx can take a byte; a transfer occurs when tx_valid && tx_ready.
- grant_active  out  1  a packet lock is held.
- grant_id  out  $clog2(NUM_REQ)  index of the locked requester; value is undefined when grant_active=0.
- arb_timeout  out  1  one-cycle pulse on forced release.

## Operation
- State machine has two states: IDLE and LOCK.
- **IDLE:**
  - If any req_valid is set, select the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Register the selection into grant_id, set grant_active, and go to LOCK.
  - If no req_valid is set, stay in IDLE.
  - req_ready is 0 for all requesters in IDLE.
- **LOCK:**
  - Only req_ready[grant_id] can be 1.
  - req_ready[grant_id] = !tx_valid || tx_ready.
  - On accept, load the byte into the output register: tx_data ← byte, tx_valid ← 1.
  - If the accepted byte has req_last=1, go to IDLE, set last_grant ← grant_id, and clear grant_active.
- **Output register (one entry):**
  - tx_valid is cleared when tx_ready=1 and no new byte is accepted in the same cycle.
  - A simultaneous downstream drain and upstream accept gives back-to-back bytes at full rate.
  - The output register may still hold the final byte after the return to IDLE; it drains independently of arbitration.
- **req_valid deasserted mid-packet:** the lock is held; the block waits indefinitely (unless timeout is enabled).
- **Fairness:** a requester that just finished a packet has lowest priority in the next arbitration.
- **Reset:**
  - Synchronous reset clears state to IDLE.
  - last_grant resets to NUM_REQ−1, so requester 0 wins first.
  - The output register is discarded even if a byte is pending.

## Timing
- Reset values:
  - tx_valid=0
  - tx_data=8'h00
  - req_ready=0
  - grant_active=0
  - grant_id=0
  - arb_timeout=0
- Arbitration latency: req_valid seen in IDLE at cycle n → grant_active=1 and req_ready high at cycle n+1 (given an empty output register or tx_ready=1).
- Byte latency: accept at edge n → tx_valid/tx_data visible after edge n (cycle n+1).
- Steady-state throughput: one byte per cycle when tx_ready is held high.
- Packet boundary: each packet costs one bubble cycle (last-byte accept → IDLE → next grant).
- req_ready is combinational from state, grant_id, tx_valid and tx_ready. No combinational path from req_valid to req_ready.

## Configuration
- Macro: UART_ARB_TIMEOUT_EN.
- **Defined:**
  - A 16-bit counter runs in LOCK. It increments each cycle where req_valid[grant_id]=0 and clears on any accept.
  - When the counter reaches TIMEOUT, go to IDLE, set last_grant ← grant_id, and pulse arb_timeout for one cycle.
  - The output register is unaffected.
  - The counter clears on entering LOCK.
- **Undefined:**
  - No counter is built and the lock is held until req_last.
  - arb_timeout is tied to 0.

## Test plan
- **Reset then single packet:** requester 2 sends 8'hA5, 8'h5A(last) with tx_ready=1.
  - Required: grant_id=2 one cycle after req_valid.
  - Required: tx_data shows A5 then 5A on consecutive cycles.
  - Required: grant_active drops after the 5A accept.
- **Round-robin:** all four requesters hold 1-byte packets (last=1) continuously.
  - Required: grant order after reset is 0,1,2,3,0.
  - Required: one bubble cycle between grants.
- **No interleave:** requester 0 has a 3-byte packet and requester 1 is valid throughout.
  - Required: tx_data shows all three requester-0 bytes before any requester-1 byte.
- **Backpressure:** tx_ready=0 for 10 cycles mid-packet.
  - Required: tx_valid/tx_data stable and req_ready=0 while the register is full.
  - Required: transfer resumes on the first tx_ready=1 cycle with no byte lost or duplicated.
- **Reset mid-packet:** assert resetn_in=0 after 2 of 4 bytes.
  - Required: next cycle tx_valid=0, req_ready=0, grant_active=0.
  - Required: after release, requester 0 wins first.
- **Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT=5):** locked requester 1 drops req_valid mid-packet.
  - Required: arb_timeout pulses exactly 5 cycles later.
  - Required: the next pending requester (2) is granted on the following cycle.
